// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// ALU control codes, data-processing cmd codes, condition codes, Op classes.
package cu_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;
   localparam logic [2:0] ALU_MOV = 3'b101;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef struct packed {
      logic [2:0] alu;
      logic       nowrite;
      logic       nop;
      logic [1:0] flagw;
   } dp_dec_t;

   // Unrecognised cmds become an ADD that writes neither registers nor flags.
   function automatic dp_dec_t decode_cmd(input logic [3:0] cmd, input logic s);
      dp_dec_t d;
      d.alu     = ALU_ADD;
      d.nowrite = 1'b0;
      d.nop     = 1'b0;
      case (cmd)
         CMD_ADD: d.alu = ALU_ADD;
         CMD_SUB: d.alu = ALU_SUB;
         CMD_AND: d.alu = ALU_AND;
         CMD_ORR: d.alu = ALU_ORR;
         CMD_EOR: d.alu = ALU_EOR;
         CMD_MOV: d.alu = ALU_MOV;
         CMD_CMP: begin
            d.alu     = ALU_SUB;
            d.nowrite = 1'b1;
         end
         default: d.nop = 1'b1;
      endcase
      d.flagw[1] = s & ~d.nop;
      d.flagw[0] = s & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
      return d;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_cond_check.sv
// Combinational ARM condition evaluation of Cond against the {N,Z,C,V} flags.
// Cond=1111 never executes.
module cond_check
   import cu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       condex
);

   logic n, z, c, v;
   assign {n, z, c, v} = flags;

   always_comb begin
      condex = 1'b0;
      case (cond)
         COND_EQ: condex = z;
         COND_NE: condex = ~z;
         COND_CS: condex = c;
         COND_CC: condex = ~c;
         COND_MI: condex = n;
         COND_PL: condex = ~n;
         COND_VS: condex = v;
         COND_VC: condex = ~v;
         COND_HI: condex = c & ~z;
         COND_LS: condex = ~c | z;
         COND_GE: condex = (n == v);
         COND_LT: condex = (n != v);
         COND_GT: condex = ~z & (n == v);
         COND_LE: condex = z | (n != v);
         COND_AL: condex = 1'b1;
         COND_NV: condex = 1'b0;
         default: condex = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style FSM sequencing the multicycle ARM-subset datapath; owns NZCV
// flags and the per-instruction condition latch. Memory states optionally wait on MemReady.
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter bit         MEM_HANDSHAKE = 1'b0,
   parameter logic [3:0] FLAGS_RESET   = 4'b0000
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Rd,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal,
   output logic [3:0] Flags
);

   state_t     state;
   logic [3:0] flags_q;
   logic       condexreg;
   logic       condex;
   logic       mem_go;
   logic       rd_pc;
   dp_dec_t    dec;

   assign mem_go = ~MEM_HANDSHAKE | MemReady;
   assign rd_pc  = (Rd == 4'd15);
   assign dec    = decode_cmd(Funct[4:1], Funct[0]);
   assign Flags  = flags_q;

   cond_check u_cond_check (
      .cond   (Cond),
      .flags  (flags_q),
      .condex (condex)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_FETCH;
         flags_q   <= FLAGS_RESET;
         condexreg <= 1'b0;
      end else begin
         case (state)
            S_FETCH:  if (mem_go) state <= S_DECODE;
            S_DECODE: begin
               condexreg <= condex;
               case (Op)
                  OP_MEM:  state <= S_MEMADR;
                  OP_DP:   state <= Funct[5] ? S_EXECUTEI : S_EXECUTER;
                  OP_BR:   state <= S_BRANCH;
                  default: state <= S_FETCH;
               endcase
            end
            S_MEMADR: state <= Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_go) state <= S_MEMWB;
            S_MEMWR:  if (mem_go) state <= S_FETCH;
            S_EXECUTER, S_EXECUTEI: begin
               // Flags see this instruction's ALU result only if it executes.
               if (condexreg && dec.flagw[1]) flags_q[3:2] <= ALUFlags[3:2];
               if (condexreg && dec.flagw[0]) flags_q[1:0] <= ALUFlags[1:0];
               state <= dec.nowrite ? S_FETCH : S_ALUWB;
            end
            S_MEMWB, S_ALUWB, S_BRANCH: state <= S_FETCH;
            default: state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      Illegal    = 1'b0;
      ImmSrc     = Op;
      RegSrc     = {Op == OP_MEM, Op == OP_BR};
      case (state)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_go;
            PCWrite   = mem_go;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            Illegal   = (Op == OP_ILL);
         end
         S_MEMADR: begin
            ALUSrcB    = 2'b01;
            ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
         end
         S_MEMRD: AdrSrc = 1'b1;
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = condexreg & mem_go;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = condexreg;
            PCWrite   = condexreg & rd_pc;
         end
         S_EXECUTER: ALUControl = dec.alu;
         S_EXECUTEI: begin
            ALUSrcB    = 2'b01;
            ALUControl = dec.alu;
         end
         S_ALUWB: begin
            RegWrite = condexreg & ~dec.nop;
            PCWrite  = condexreg & rd_pc & ~dec.nop;
         end
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = condexreg;
         end
         default: ;
      endcase
      // Reset is asynchronous, so enables are also blocked combinationally.
      if (rst) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised instruction stream checked cycle by cycle against an
// instruction-level reference model of the control unit.
module tb_multicycle_control_unit;

   localparam logic [3:0] FR = 4'b0101;

   typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                     P_EXR, P_EXI, P_ALUWB, P_BRANCH} phase_t;
   typedef struct {phase_t p; logic mr;} step_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] Rd, Cond, ALUFlags, Flags;
   logic [1:0] Op, ResultSrc, ALUSrcB, ImmSrc, RegSrc;
   logic [5:0] Funct;
   logic       MemReady;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Illegal;
   logic [2:0] ALUControl;

   int checks = 0;
   int failures = 0;

   logic [3:0] m_flags;
   logic       m_cx;

   always #5 clk = ~clk;

   multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .FLAGS_RESET(FR)) dut (
      .clk(clk), .rst(rst), .Rd(Rd), .Op(Op), .Funct(Funct), .Cond(Cond),
      .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
      .ALUControl(ALUControl), .Illegal(Illegal), .Flags(Flags)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Condition codes come in true/inverted pairs; bit 0 selects the inverse.
   function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      if (c == 4'hE) return 1'b1;
      return base ^ c[0];
   endfunction

   function automatic logic [2:0] model_alu(input logic [3:0] cmd);
      case (cmd)
         4'b0100: return 3'd0;
         4'b0010, 4'b1010: return 3'd1;
         4'b0000: return 3'd2;
         4'b1100: return 3'd3;
         4'b0001: return 3'd4;
         4'b1101: return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic is_nop(input logic [3:0] cmd);
      return !(cmd inside {4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b0001, 4'b1101});
   endfunction

   function automatic logic [17:0] exp_ctrl(input phase_t p, input logic mr, input logic [1:0] op,
                                            input logic [5:0] fn, input logic [3:0] rd, input logic cx);
      logic pcw, adr, mw, irw, rw, sa, ill;
      logic [1:0] res, sb;
      logic [2:0] alu;
      logic nop;
      {pcw, adr, mw, irw, rw, sa, ill} = 7'b0;
      res = 2'b00; sb = 2'b00; alu = 3'd0;
      nop = is_nop(fn[4:1]);
      case (p)
         P_FETCH:  begin sa = 1; sb = 2; res = 2; pcw = mr; irw = mr; end
         P_DECODE: begin sa = 1; sb = 2; res = 2; ill = (op == 2'b11); end
         P_MEMADR: begin sb = 1; alu = fn[3] ? 3'd0 : 3'd1; end
         P_MEMRD:  adr = 1;
         P_MEMWR:  begin adr = 1; mw = cx && mr; end
         P_MEMWB:  begin res = 1; rw = cx; pcw = cx && rd == 15; end
         P_EXR:    alu = model_alu(fn[4:1]);
         P_EXI:    begin sb = 1; alu = model_alu(fn[4:1]); end
         P_ALUWB:  begin rw = cx && !nop; pcw = cx && rd == 15 && !nop; end
         P_BRANCH: begin sb = 1; res = 2; pcw = cx; end
         default: ;
      endcase
      return {pcw, adr, mw, irw, rw, sa, res, sb, op, op == 2'b01, op == 2'b10, alu, ill};
   endfunction

   function automatic logic [17:0] obs_ctrl();
      return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ResultSrc, ALUSrcB,
              ImmSrc, RegSrc, ALUControl, Illegal};
   endfunction

   // One cycle: entered just after a rising edge, leaves just after the next.
   task automatic step(input phase_t p, input logic mr, input string tag);
      logic [3:0] cmd;
      cmd = Funct[4:1];
      MemReady = mr;
      @(negedge clk);
      check_val($sformatf("%s/%s ctrl", tag, p.name()), 32'(obs_ctrl()),
                32'(exp_ctrl(p, mr, Op, Funct, Rd, m_cx)));
      check_val($sformatf("%s/%s flags", tag, p.name()), 32'(Flags), 32'(m_flags));
      if (p == P_DECODE) m_cx = model_cond(Cond, m_flags);
      if ((p == P_EXR || p == P_EXI) && m_cx && Funct[0] && !is_nop(cmd)) begin
         m_flags[3:2] = ALUFlags[3:2];
         if (cmd inside {4'b0100, 4'b0010, 4'b1010}) m_flags[1:0] = ALUFlags[1:0];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] cond,
                            input logic [3:0] rd, input logic [3:0] af, input int fw, input int mw,
                            input string tag);
      step_t q[$];
      Op = op; Funct = fn; Cond = cond; Rd = rd; ALUFlags = af;
      for (int i = 0; i < fw; i++) q.push_back('{P_FETCH, 1'b0});
      q.push_back('{P_FETCH, 1'b1});
      q.push_back('{P_DECODE, 1'($urandom_range(0, 1))});
      case (op)
         2'b00: begin
            q.push_back('{fn[5] ? P_EXI : P_EXR, 1'($urandom_range(0, 1))});
            if (fn[4:1] != 4'b1010) q.push_back('{P_ALUWB, 1'($urandom_range(0, 1))});
         end
         2'b01: begin
            q.push_back('{P_MEMADR, 1'($urandom_range(0, 1))});
            for (int i = 0; i < mw; i++) q.push_back('{fn[0] ? P_MEMRD : P_MEMWR, 1'b0});
            q.push_back('{fn[0] ? P_MEMRD : P_MEMWR, 1'b1});
            if (fn[0]) q.push_back('{P_MEMWB, 1'($urandom_range(0, 1))});
         end
         2'b10: q.push_back('{P_BRANCH, 1'($urandom_range(0, 1))});
         default: ;
      endcase
      foreach (q[i]) step(q[i].p, q[i].mr, tag);
   endtask

   initial begin
      logic [1:0] op;
      logic [5:0] fn;
      logic [3:0] rd;
      rst = 1'b1; Op = 2'b00; Funct = 6'd0; Cond = 4'hE; Rd = 4'd0;
      ALUFlags = 4'd0; MemReady = 1'b1;
      m_flags = FR; m_cx = 1'b0;
      #12;
      check_val("reset ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(P_FETCH, 1'b0, Op, Funct, Rd, 1'b0)));
      check_val("reset flags", 32'(Flags), 32'(FR));
      @(posedge clk); #1;
      rst = 1'b0;

      run_instr(2'b00, 6'b001001, 4'hE, 4'd3, 4'b0110, 0, 0, "add");
      run_instr(2'b00, 6'b010101, 4'hE, 4'd0, 4'b0100, 0, 0, "cmp_z1");
      run_instr(2'b10, 6'b000000, 4'h1, 4'd0, 4'b0000, 0, 0, "bne_nt");
      run_instr(2'b00, 6'b010101, 4'hE, 4'd0, 4'b0000, 0, 0, "cmp_z0");
      run_instr(2'b10, 6'b000000, 4'h1, 4'd0, 4'b0000, 0, 0, "bne_t");
      run_instr(2'b01, 6'b000001, 4'hE, 4'd5, 4'b0000, 0, 2, "ldr_wait");
      run_instr(2'b00, 6'b010101, 4'hE, 4'd0, 4'b0100, 0, 0, "cmp");
      run_instr(2'b00, 6'b001000, 4'h0, 4'd2, 4'b1111, 0, 0, "addeq");
      run_instr(2'b00, 6'b001000, 4'h1, 4'd2, 4'b1111, 0, 0, "addne");
      run_instr(2'b11, 6'b000000, 4'hE, 4'd15, 4'b1111, 1, 0, "illegal");
      run_instr(2'b00, 6'b001001, 4'hE, 4'd15, 4'b1001, 0, 0, "add_pc");
      run_instr(2'b01, 6'b001001, 4'hE, 4'd15, 4'b0000, 0, 0, "ldr_pc");
      run_instr(2'b00, 6'b111011, 4'hF, 4'd1, 4'b1111, 0, 0, "mov_nv");

      for (int n = 0; n < 160; n++) begin
         op = 2'($urandom_range(0, 3));
         fn = 6'($urandom);
         rd = 4'($urandom);
         if (op == 2'b00 && is_nop(fn[4:1])) rd = 4'($urandom_range(0, 14));
         run_instr(op, fn, 4'($urandom), rd, 4'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2), "rand");
      end

      // Reset arriving in the middle of a store's memory-write cycle.
      run_instr(2'b00, 6'b010101, 4'hE, 4'd0, 4'b1010, 0, 0, "cmp_pre");
      Op = 2'b01; Funct = 6'b001000; Cond = 4'hE; Rd = 4'd4; ALUFlags = 4'd0;
      step(P_FETCH, 1'b1, "str_rst");
      step(P_DECODE, 1'b1, "str_rst");
      step(P_MEMADR, 1'b1, "str_rst");
      MemReady = 1'b1;
      @(negedge clk);
      check_val("str_rst/MEMWR ctrl", 32'(obs_ctrl()),
                32'(exp_ctrl(P_MEMWR, 1'b1, Op, Funct, Rd, m_cx)));
      #1 rst = 1'b1;
      #1;
      check_val("rst_memwr memwrite", 32'(MemWrite), 32'd0);
      check_val("rst_memwr ctrl", 32'(obs_ctrl()),
                32'(exp_ctrl(P_FETCH, 1'b0, Op, Funct, Rd, 1'b0)));
      check_val("rst_memwr flags", 32'(Flags), 32'(FR));
      m_flags = FR;
      m_cx = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(2'b00, 6'b001001, 4'hE, 4'd7, 4'b1000, 0, 0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
